// File: rtl/lcd_arbiter_if.sv
`default_nettype none
// ============================================================================
// lcd_arbiter_if : requester, LCD-controller and status bundle of lcd_arbiter
// Rev 1.0
// ============================================================================
interface lcd_arbiter_if;
  logic       iREQ0;
  logic       iREQ1;
  logic [7:0] iDATA0;
  logic [7:0] iDATA1;
  logic       iRS0;
  logic       iRS1;
  logic       iLOCK0;
  logic       iLOCK1;
  logic       oACK0;
  logic       oACK1;
  logic [1:0] oGRANT;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS;
  logic       oLCD_Start;
  logic       iLCD_Done;
  logic       oBUSY;

  modport slave (
    input  iREQ0, iREQ1, iDATA0, iDATA1, iRS0, iRS1, iLOCK0, iLOCK1, iLCD_Done,
    output oACK0, oACK1, oGRANT, oLCD_DATA, oLCD_RS, oLCD_Start, oBUSY
  );

  modport master (
    output iREQ0, iREQ1, iDATA0, iDATA1, iRS0, iRS1, iLOCK0, iLOCK1, iLCD_Done,
    input  oACK0, oACK1, oGRANT, oLCD_DATA, oLCD_RS, oLCD_Start, oBUSY
  );
endinterface
`default_nettype wire

// File: rtl/lcd_arbiter.sv
`default_nettype none
// ============================================================================
// lcd_arbiter : two-requester round-robin arbiter with lock for one LCD port
// Rev 1.0
// ============================================================================
module lcd_arbiter #(
  parameter int unsigned      DLY_W   = 18,
  parameter logic [DLY_W-1:0] DLY_MAX = 18'h3FFFE
) (
  input wire           iCLK,
  input wire           iRST_N,
  lcd_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_DONE = 2'd1;
  localparam logic [1:0] S_DELAY     = 2'd2;
  localparam logic [1:0] S_ACK       = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [DLY_W-1:0] r_cnt;
  logic             r_last;
  logic             r_lock;
  logic [7:0]       r_data;
  logic             r_rs;
  logic             w_owner_lock;
  logic             w_grant;
  logic             w_winner;

  // r_last doubles as the current owner: it is updated at every grant.
  assign w_owner_lock = r_last ? bus.iLOCK1 : bus.iLOCK0;

  always_comb begin
    w_grant  = 1'b0;
    w_winner = r_last;
    if (r_lock && w_owner_lock) begin
      w_grant = r_last ? bus.iREQ1 : bus.iREQ0;
    end else if (bus.iREQ0 && bus.iREQ1) begin
      w_grant  = 1'b1;
      w_winner = ~r_last;
    end else if (bus.iREQ0) begin
      w_grant  = 1'b1;
      w_winner = 1'b0;
    end else if (bus.iREQ1) begin
      w_grant  = 1'b1;
      w_winner = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_grant) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.iLCD_Done) w_next = S_DELAY;
      S_DELAY:     if (r_cnt >= DLY_MAX) w_next = S_ACK;
      S_ACK:       w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_cnt  <= '0;
      r_last <= 1'b1;
      r_lock <= 1'b0;
      r_data <= 8'h00;
      r_rs   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_grant) begin
        r_last <= w_winner;
        r_data <= w_winner ? bus.iDATA1 : bus.iDATA0;
        r_rs   <= w_winner ? bus.iRS1 : bus.iRS0;
      end
      // Counter sits at zero outside DELAY, so entering DELAY always starts from 0.
      if (r_state == S_DELAY && r_cnt < DLY_MAX) begin
        r_cnt <= r_cnt + DLY_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (r_state == S_ACK) begin
        r_lock <= w_owner_lock;
      end else if (!w_owner_lock) begin
        r_lock <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.oBUSY      = (r_state != S_IDLE);
    bus.oLCD_Start = (r_state == S_WAIT_DONE);
    bus.oACK0      = (r_state == S_ACK) && !r_last;
    bus.oACK1      = (r_state == S_ACK) && r_last;
    bus.oGRANT     = 2'b00;
    if (r_state != S_IDLE || r_lock) begin
      bus.oGRANT = r_last ? 2'b10 : 2'b01;
    end
  end

  assign bus.oLCD_DATA = r_data;
  assign bus.oLCD_RS   = r_rs;
endmodule
`default_nettype wire

// File: doc/lcd_arbiter.md
LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 Parameter DLY_MAX, default 18'h3FFFE, sets the post-write settle count (5.2 ms at 50 MHz).
REQ-002 Parameter DLY_W, default 18, sets the delay counter width.
REQ-003 iCLK  in  1  sole clock; all state on rising edge.
REQ-004 iRST_N  in  1  asynchronous, active-low reset.
REQ-005 iREQ0 / iREQ1  in  1  requester n wants one LCD write.
REQ-006 iDATA0 / iDATA1  in  8  byte for requester n; stable while iREQn high.
REQ-007 iRS0 / iRS1  in  1  register select for requester n (0 = instruction, 1 = data).
REQ-008 iLOCK0 / iLOCK1  in  1  requester n keeps the grant across consecutive writes.
REQ-009 oACK0 / oACK1  out  1  one-cycle pulse when requester n's write plus settle delay completes.
REQ-010 oGRANT  out  2  one-hot current owner (bit n = requester n); 2'b00 when idle and unlocked.
REQ-011 oLCD_DATA  out  8  byte to the LCD_Controller iDATA.
REQ-012 oLCD_RS  out  1  to the LCD_Controller iRS.
REQ-013 oLCD_Start  out  1  to the LCD_Controller iStart.
REQ-014 iLCD_Done  in  1  from the LCD_Controller oDone.
REQ-015 oBUSY  out  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, WAIT_DONE, DELAY and ACK.
REQ-017 In IDLE with a grantable request: latch the winner's data and RS into oLCD_DATA/oLCD_RS, set oLCD_Start=1, set oGRANT, and go to WAIT_DONE on the same edge.
REQ-018 Arbitration is round-robin on pointer LAST (last served). If both request, the requester other than LAST wins. If one requests, it wins. LAST updates at grant.
REQ-019 If a lock is held by requester n, IDLE SHALL grant only requester n and ignore the other requester, even if requester n is not requesting.
REQ-020 The lock is set at the ACK state when the owner's iLOCKn=1. It is cleared in any cycle in which the owner's iLOCKn=0, including in IDLE.
REQ-021 In WAIT_DONE: hold oLCD_Start=1 and the latched data. When iLCD_Done=1 is sampled, set oLCD_Start=0, clear the counter, and go to DELAY. No timeout.
REQ-022 In DELAY: if count < DLY_MAX, increment; else clear the count and go to ACK. DELAY lasts exactly DLY_MAX+1 cycles. DLY_MAX=0 gives 1 cycle.
REQ-023 In ACK: pulse the owner's oACKn for exactly one cycle, then return to IDLE. The earliest next grant is on the cycle after IDLE is entered.
REQ-024 Latency: from iREQn sampled in IDLE to the oACKn pulse = 1 + (WAIT_DONE cycles) + (DLY_MAX+1) + 1 cycles.
REQ-025 A requester dropping iREQn or changing iDATAn after grant SHALL NOT abort or alter the transfer. oACKn still pulses.
REQ-026 oLCD_DATA and oLCD_RS change only at grant. They hold their last value otherwise.
REQ-027 oACK0 and oACK1 are never high in the same cycle.
REQ-028 oGRANT returns to 2'b00 on entering IDLE unless a lock is held, in which case it stays on the owner.
REQ-029 If iLCD_Done is high while not in WAIT_DONE, it SHALL be ignored.

Reset
REQ-030 On iRST_N=0, asynchronously and at any state (including mid-transfer):
- state=IDLE, counter=0, lock cleared, LAST=1 (so requester 0 wins first).
- oLCD_Start=0, oLCD_DATA=8'h00, oLCD_RS=0, oACK0=oACK1=0, oGRANT=2'b00, oBUSY=0.
REQ-031 No oACK SHALL be issued for a transfer interrupted by reset.

Verification (DLY_MAX=3; controller model asserts Done 4 cycles after Start rises)
REQ-032 Single write: iREQ0=1, iDATA0=8'h38, iRS0=0 -> oLCD_Start=1, oLCD_DATA=8'h38, oLCD_RS=0, oGRANT=2'b01; oACK0 pulses once, 4 delay cycles after Done.
REQ-033 Contention: iREQ0 and iREQ1 both held high after reset -> grant order 0,1,0,1. ACKs alternate and never overlap.
REQ-034 Lock: iREQ0=1, iLOCK0=1, iREQ1=1 for 3 writes -> oGRANT stays 2'b01 for all 3. After iLOCK0=0, the next grant goes to requester 1.
REQ-035 Stall: hold iLCD_Done=0 for 1000 cycles -> oLCD_Start stays 1, oBUSY=1, no oACK, no counter advance.
REQ-036 Reset mid-DELAY: assert iRST_N=0 at count=2 -> all outputs reach reset values immediately, no oACK. After release, pending iREQ1 is granted with requester 0 idle.
REQ-037 Spurious Done: pulse iLCD_Done in IDLE and in DELAY -> no state change, no extra ACK.
